// File: rtl/credit_retry_requester.sv
// credit_retry_requester
//   Initiator end of a credit/retry request channel. Local requests go through a one-beat launch
//   register to the receiver. A beat the receiver retries is parked in a per-id table. When the
//   receiver grants a credit for that id, the beat is replayed with tx_credit_o=1. No request is
//   ever dropped, and each id has at most one outstanding beat.
// Ports
//   clk, reset                      clock; synchronous active-high reset
//   req_valid_i/req_id_i/req_payload_i/req_ready_o   local request handshake
//   tx_valid_o/tx_id_o/tx_payload_o/tx_credit_o      registered downstream beat
//   tx_ready_i, tx_retry_i          receiver accept / reject of the current beat
//   credit_gnt_i, credit_id_i       credit grant for one id
//   parked_cnt_o                    number of PARKED or CREDITED entries
//   err_o                           sticky protocol error
module credit_retry_requester #(
  parameter int unsigned ID_W      = 3,
  parameter int unsigned PAYLOAD_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid_i,
  input  logic [ID_W-1:0]      req_id_i,
  input  logic [PAYLOAD_W-1:0] req_payload_i,
  output logic                 req_ready_o,
  output logic                 tx_valid_o,
  output logic [ID_W-1:0]      tx_id_o,
  output logic [PAYLOAD_W-1:0] tx_payload_o,
  output logic                 tx_credit_o,
  input  logic                 tx_ready_i,
  input  logic                 tx_retry_i,
  input  logic                 credit_gnt_i,
  input  logic [ID_W-1:0]      credit_id_i,
  output logic [ID_W:0]        parked_cnt_o,
  output logic                 err_o
);

  localparam int unsigned NumEnt = 2 ** ID_W;

  localparam logic [1:0] EntEmpty    = 2'd0;
  localparam logic [1:0] EntParked   = 2'd1;
  localparam logic [1:0] EntCredited = 2'd2;

  localparam logic [ID_W:0] CntOne = {{ID_W{1'b0}}, 1'b1};

  logic [1:0]           ent_st_q [NumEnt];
  logic [1:0]           ent_st_d [NumEnt];
  logic [PAYLOAD_W-1:0] ent_pl_q [NumEnt];
  logic [PAYLOAD_W-1:0] ent_pl_d [NumEnt];

  logic                 tx_valid_q, tx_valid_d;
  logic [ID_W-1:0]      tx_id_q, tx_id_d;
  logic [PAYLOAD_W-1:0] tx_payload_q, tx_payload_d;
  logic                 tx_credit_q, tx_credit_d;
  logic [ID_W:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic            free;
  logic            retry_ev;
  logic            cred_any;
  logic [ID_W-1:0] cred_idx;
  logic            req_ready;
  logic            replay_load;

  // Launch register can take a new beat when empty or its beat leaves this cycle.
  // Ready and retry together count as ready, so only a bare retry parks the beat.
  always_comb begin
    free     = ~tx_valid_q | tx_ready_i | tx_retry_i;
    retry_ev = tx_valid_q & tx_retry_i & ~tx_ready_i;
  end

  // Lowest-id CREDITED entry wins the replay slot.
  always_comb begin
    cred_any = 1'b0;
    cred_idx = '0;
    for (int i = 0; i < int'(NumEnt); i++) begin
      if (!cred_any && ent_st_q[i] == EntCredited) begin
        cred_any = 1'b1;
        cred_idx = ID_W'(i);
      end
    end
  end

  // Blocking a request whose id is still in flight (and not being accepted) keeps per-id order.
  always_comb begin
    req_ready = free & ~cred_any & (ent_st_q[req_id_i] == EntEmpty) &
                ~(tx_valid_q & (tx_id_q == req_id_i) & ~tx_ready_i);
  end

  always_comb begin
    for (int i = 0; i < int'(NumEnt); i++) begin
      ent_st_d[i] = ent_st_q[i];
      ent_pl_d[i] = ent_pl_q[i];
    end
    tx_valid_d   = tx_valid_q;
    tx_id_d      = tx_id_q;
    tx_payload_d = tx_payload_q;
    tx_credit_d  = tx_credit_q;
    err_d        = err_q;
    replay_load  = 1'b0;

    if (retry_ev) begin
      // A retried replay is a receiver protocol violation; keep the credit it already holds.
      ent_st_d[tx_id_q] = tx_credit_q ? EntCredited : EntParked;
      ent_pl_d[tx_id_q] = tx_payload_q;
      if (tx_credit_q) begin
        err_d = 1'b1;
      end
    end

    // Judged on the registered state, so a credit for an id parked this same cycle is an error.
    if (credit_gnt_i) begin
      if (ent_st_q[credit_id_i] == EntParked) begin
        ent_st_d[credit_id_i] = EntCredited;
      end else begin
        err_d = 1'b1;
      end
    end

    if (free) begin
      if (cred_any) begin
        tx_valid_d         = 1'b1;
        tx_id_d            = cred_idx;
        tx_payload_d       = ent_pl_q[cred_idx];
        tx_credit_d        = 1'b1;
        ent_st_d[cred_idx] = EntEmpty;
        replay_load        = 1'b1;
      end else if (req_valid_i && req_ready) begin
        tx_valid_d   = 1'b1;
        tx_id_d      = req_id_i;
        tx_payload_d = req_payload_i;
        tx_credit_d  = 1'b0;
      end else begin
        tx_valid_d  = 1'b0;
        tx_credit_d = 1'b0;
      end
    end

    unique case ({retry_ev, replay_load})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NumEnt); i++) begin
        ent_st_q[i] <= EntEmpty;
        ent_pl_q[i] <= '0;
      end
      tx_valid_q   <= 1'b0;
      tx_id_q      <= '0;
      tx_payload_q <= '0;
      tx_credit_q  <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NumEnt); i++) begin
        ent_st_q[i] <= ent_st_d[i];
        ent_pl_q[i] <= ent_pl_d[i];
      end
      tx_valid_q   <= tx_valid_d;
      tx_id_q      <= tx_id_d;
      tx_payload_q <= tx_payload_d;
      tx_credit_q  <= tx_credit_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    req_ready_o  = req_ready;
    tx_valid_o   = tx_valid_q;
    tx_id_o      = tx_id_q;
    tx_payload_o = tx_payload_q;
    tx_credit_o  = tx_credit_q;
    parked_cnt_o = cnt_q;
    err_o        = err_q;
  end

endmodule
